// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the multi-channel timer.
//   - state_t and its IDLE / COUNT / PAUSE encodings. These are plain
//     localparams so that older code can use the same values.
//   - Default channel width and prescaler width.
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t COUNT = 2'd1;
  localparam state_t PAUSE = 2'd2;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_PRESC_W = 16;

endpackage

// File: rtl/multi_timer_if.sv
// -----------------------------------------------------------------------------
// multi_timer_if
//   Control and status bundle of the multi-channel timer.
//   master : the block that drives the timer
//            outputs: Tick_Div, Start, Pause, Abort, Periodic, Tiempo
//            inputs : Busy, Paused, Done, Remaining
//   slave  : the timer, with every direction reversed
//   Per-channel vectors use bit i for channel i. The wide buses use
//   [i*WIDTH +: WIDTH] for channel i.
// -----------------------------------------------------------------------------
interface multi_timer_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = timer_pkg::DEFAULT_WIDTH,
  parameter int PRESC_W  = timer_pkg::DEFAULT_PRESC_W
);

  logic [PRESC_W-1:0]        Tick_Div;
  logic [CHANNELS-1:0]       Start;
  logic [CHANNELS-1:0]       Pause;
  logic [CHANNELS-1:0]       Abort;
  logic [CHANNELS-1:0]       Periodic;
  logic [CHANNELS*WIDTH-1:0] Tiempo;
  logic [CHANNELS-1:0]       Busy;
  logic [CHANNELS-1:0]       Paused;
  logic [CHANNELS-1:0]       Done;
  logic [CHANNELS*WIDTH-1:0] Remaining;

  modport master (
    output Tick_Div, Start, Pause, Abort, Periodic, Tiempo,
    input  Busy, Paused, Done, Remaining
  );

  modport slave (
    input  Tick_Div, Start, Pause, Abort, Periodic, Tiempo,
    output Busy, Paused, Done, Remaining
  );

endinterface

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
//   One down-counting timer channel. It contains the IDLE/COUNT/PAUSE state
//   machine, the counter, the reload value and the mode register.
//   Inputs : Clock, Reset (async, active-high), tick (shared prescaler strobe),
//            start, pause, abort, periodic, tiempo (load value)
//   Outputs: busy, paused, done (registered one-clock pulse), remaining
// -----------------------------------------------------------------------------
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             periodic,
  input  logic [WIDTH-1:0] tiempo,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] reload;
  logic             mode;

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever order the branches are
  // written in.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      counter <= '0;
      reload  <= '0;
      mode    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort is a silent cancel. No Done pulse is produced.
        state   <= IDLE;
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !pause) begin
              if (tiempo != '0) begin
                counter <= tiempo;
                reload  <= tiempo;
                mode    <= periodic;
                state   <= COUNT;
              end else begin
                // A zero-length delay completes at once.
                done <= 1'b1;
              end
            end
          end
          COUNT: begin
            if (pause) begin
              // Enter PAUSE. A tick that arrives in this clock is dropped.
              state <= PAUSE;
            end else if (tick) begin
              if (counter == WIDTH'(1)) begin
                done <= 1'b1;
                if (mode) begin
                  counter <= reload;
                end else begin
                  counter <= '0;
                  state   <= IDLE;
                end
              end else begin
                counter <= counter - WIDTH'(1);
              end
            end
          end
          PAUSE: begin
            // The resume clock only changes state. Counting restarts on the
            // next tick.
            if (!pause) state <= COUNT;
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

  assign busy      = (state == COUNT) || (state == PAUSE);
  assign paused    = (state == PAUSE);
  assign remaining = counter;

endmodule

// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//   N-channel programmable down-counter timer with a shared prescaler.
//   Ports: Clock, Reset (async, active-high), bus (multi_timer_if.slave)
//     bus.Tick_Div   shared divisor, one tick every Tick_Div+1 clocks
//     bus.Start/Pause/Abort/Periodic/Tiempo   per-channel controls
//     bus.Busy/Paused/Done/Remaining          per-channel status
// -----------------------------------------------------------------------------
module multi_timer
  import timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESC_W  = DEFAULT_PRESC_W
) (
  input  logic        Clock,
  input  logic        Reset,
  multi_timer_if.slave bus
);

  logic [PRESC_W-1:0]        presc_cnt;
  logic                      tick;
  logic [CHANNELS-1:0]       busy_v;
  logic [CHANNELS-1:0]       paused_v;
  logic [CHANNELS-1:0]       done_v;
  logic [CHANNELS*WIDTH-1:0] remaining_v;

  // The compare uses >= rather than ==. If the divisor is lowered below the
  // current count, the next clock still ticks and the count never runs away.
  assign tick = (presc_cnt >= bus.Tick_Div);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)     presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + PRESC_W'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .Clock     (Clock),
      .Reset     (Reset),
      .tick      (tick),
      .start     (bus.Start[i]),
      .pause     (bus.Pause[i]),
      .abort     (bus.Abort[i]),
      .periodic  (bus.Periodic[i]),
      .tiempo    (bus.Tiempo[i*WIDTH +: WIDTH]),
      .busy      (busy_v[i]),
      .paused    (paused_v[i]),
      .done      (done_v[i]),
      .remaining (remaining_v[i*WIDTH +: WIDTH])
    );
  end

  assign bus.Busy      = busy_v;
  assign bus.Paused    = paused_v;
  assign bus.Done      = done_v;
  assign bus.Remaining = remaining_v;

endmodule

// File: tb/tb_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_timer
//   Self-checking bench for multi_timer (4 channels, 16-bit, 16-bit prescaler).
//   A behavioural reference model is checked against the DUT after every
//   clock. Table vectors, directed corner-case sequences and random traffic
//   drive the DUT.
// -----------------------------------------------------------------------------
module tb_multi_timer;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int PW = 16;

  logic Clock;
  logic Reset;

  multi_timer_if #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) tif ();

  multi_timer #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (tif)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) $display("FAIL %s: got %0h, expected %0h", name, act, want);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // Each channel is described by an "active" flag, a "held" flag and an
  // integer count. The prescaler is an integer phase.
  bit m_act  [CH];
  bit m_held [CH];
  bit m_per  [CH];
  bit m_done [CH];
  int m_cnt  [CH];
  int m_rel  [CH];
  int m_pre;

  task automatic model_reset();
    m_pre = 0;
    for (int c = 0; c < CH; c++) begin
      m_act[c] = 0; m_held[c] = 0; m_per[c] = 0; m_done[c] = 0;
      m_cnt[c] = 0; m_rel[c] = 0;
    end
  endtask

  task automatic model_step();
    bit tick;
    tick  = (m_pre >= int'(tif.Tick_Div));
    m_pre = tick ? 0 : m_pre + 1;
    for (int c = 0; c < CH; c++) begin
      int t;
      t = int'(tif.Tiempo[c*W +: W]);
      m_done[c] = 0;
      if (tif.Abort[c]) begin
        m_act[c] = 0; m_held[c] = 0; m_cnt[c] = 0;
      end else if (!m_act[c]) begin
        if (tif.Start[c] && !tif.Pause[c]) begin
          if (t == 0) m_done[c] = 1;
          else begin
            m_act[c] = 1; m_cnt[c] = t; m_rel[c] = t; m_per[c] = tif.Periodic[c];
          end
        end
      end else if (m_held[c]) begin
        if (!tif.Pause[c]) m_held[c] = 0;
      end else if (tif.Pause[c]) begin
        m_held[c] = 1;
      end else if (tick) begin
        if (m_cnt[c] == 1) begin
          m_done[c] = 1;
          if (m_per[c]) m_cnt[c] = m_rel[c];
          else begin m_cnt[c] = 0; m_act[c] = 0; end
        end else m_cnt[c] = m_cnt[c] - 1;
      end
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0]   eb, ep, ed;
    logic [CH*W-1:0] er;
    for (int c = 0; c < CH; c++) begin
      eb[c] = m_act[c];
      ep[c] = m_act[c] && m_held[c];
      ed[c] = m_done[c];
      er[c*W +: W] = W'(m_cnt[c]);
    end
    check("model_busy",      64'(tif.Busy),      64'(eb));
    check("model_paused",    64'(tif.Paused),    64'(ep));
    check("model_done",      64'(tif.Done),      64'(ed));
    check("model_remaining", 64'(tif.Remaining), 64'(er));
  endtask

  // One clock: the model consumes the inputs seen at the edge, and the
  // outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge Clock);
    if (Reset) model_reset();
    else       model_step();
    #1;
    compare_model();
  endtask

  task automatic clear_inputs();
    tif.Tick_Div = '0;
    tif.Start    = '0;
    tif.Pause    = '0;
    tif.Abort    = '0;
    tif.Periodic = '0;
    tif.Tiempo   = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    clear_inputs();
    model_reset();
    step();
    step();
    Reset = 1'b0;
  endtask

  // ---------------- channel-0 vector table ----------------
  typedef struct {
    logic        start, pause, abort, periodic;
    logic [15:0] tiempo;
    logic        busy, paused, done;
    logic [15:0] rem;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int k, d0, d3, n, pulses, last;
    bit ok, ch1_done, found, always_busy, rem_ok;

    Reset = 1'b1;
    clear_inputs();
    model_reset();
    step();
    check("reset_outputs", {60'(tif.Remaining), tif.Busy, tif.Paused, tif.Done}, 64'd0);
    Reset = 1'b0;
    step();

    //           start  pause  abort  per    tiempo  busy   paused done   rem
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0, 1'b0, 16'd5};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0, 1'b0, 16'd4};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 1'b1, 1'b0, 1'b0, 16'd4};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd9, 1'b1, 1'b0, 1'b0, 16'd3};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd9, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 1'b0, 1'b0, 1'b0, 16'd0};

    for (int i = 0; i < 16; i++) begin
      tif.Start[0]    = tbl[i].start;
      tif.Pause[0]    = tbl[i].pause;
      tif.Abort[0]    = tbl[i].abort;
      tif.Periodic[0] = tbl[i].periodic;
      tif.Tiempo[0 +: W] = tbl[i].tiempo;
      step();
      check($sformatf("vec%0d", i),
            {45'd0, tif.Busy[0], tif.Paused[0], tif.Done[0], tif.Remaining[0 +: W]},
            {45'd0, tbl[i].busy, tbl[i].paused, tbl[i].done, tbl[i].rem});
    end

    // ---------------- reset in the middle of a count ----------------
    do_reset();
    tif.Tiempo[0 +: W] = 16'd10;
    tif.Start[0] = 1'b1;
    step();
    tif.Start[0] = 1'b0;
    step();
    step();
    Reset = 1'b1;
    model_reset();
    #1;
    check("reset_midcount", {60'(tif.Remaining), tif.Busy, tif.Paused, tif.Done}, 64'd0);
    step();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("idle_after_reset", 64'(tif.Busy[0]), 64'd0);

    // ---------------- prescaler with periodic mode on channel 1 ----------------
    do_reset();
    tif.Tick_Div = 16'd3;
    tif.Tiempo[1*W +: W] = 16'd2;
    tif.Periodic[1] = 1'b1;
    tif.Start[1] = 1'b1;
    step();
    tif.Start[1] = 1'b0;
    pulses = 0; last = 0; always_busy = 1; rem_ok = 1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!tif.Busy[1]) always_busy = 0;
      if (tif.Remaining[1*W +: W] != 16'd1 && tif.Remaining[1*W +: W] != 16'd2) rem_ok = 0;
      if (tif.Done[1]) begin
        if (pulses == 0) check("periodic_first_done", 64'(i), 64'd7);
        else             check("periodic_gap", 64'(i - last), 64'd8);
        pulses++;
        last = i;
      end
    end
    check("periodic_pulses", 64'(pulses), 64'd5);
    check("periodic_busy", 64'(always_busy), 64'd1);
    check("periodic_rem", 64'(rem_ok), 64'd1);

    // ---------------- pause and resume on channel 2 ----------------
    do_reset();
    tif.Tiempo[2*W +: W] = 16'd6;
    tif.Start[2] = 1'b1;
    step();
    tif.Start[2] = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (tif.Remaining[2*W +: W] == 16'd3) begin found = 1; break; end
      step();
    end
    check("pause_reach3", 64'(found), 64'd1);
    tif.Pause[2] = 1'b1;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(tif.Paused[2] && tif.Busy[2] && tif.Remaining[2*W +: W] == 16'd3)) ok = 0;
    end
    check("pause_hold", 64'(ok), 64'd1);
    tif.Pause[2] = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (tif.Done[2]) break;
    end
    // The resume edge does not count, and three ticks follow it.
    check("resume_latency", 64'(n), 64'd4);

    // ---------------- multi-channel independence ----------------
    do_reset();
    tif.Tiempo[0*W +: W] = 16'd3;
    tif.Tiempo[1*W +: W] = 16'd5;
    tif.Tiempo[3*W +: W] = 16'd7;
    tif.Start = 4'b1011;
    step();
    tif.Start = '0;
    tif.Abort[1] = 1'b1;
    d0 = 0; d3 = 0; ch1_done = 0;
    for (k = 2; k <= 20; k++) begin
      step();
      if (tif.Done[0] && d0 == 0) d0 = k;
      if (tif.Done[3] && d3 == 0) d3 = k;
      if (tif.Done[1]) ch1_done = 1;
    end
    check("multi_done0", 64'(d0), 64'd4);
    check("multi_done3", 64'(d3), 64'd8);
    check("multi_ch1_silent", 64'(ch1_done), 64'd0);

    // ---------------- random traffic against the model ----------------
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) tif.Tick_Div = PW'($urandom_range(0, 3));
      for (int c = 0; c < CH; c++) begin
        tif.Start[c]    = ($urandom_range(0, 99) < 30);
        tif.Pause[c]    = ($urandom_range(0, 99) < 10);
        tif.Abort[c]    = ($urandom_range(0, 99) < 3);
        tif.Periodic[c] = ($urandom_range(0, 99) < 50);
        tif.Tiempo[c*W +: W] = W'($urandom_range(0, 12));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
